link_fault_injector: RTL and testbench

- Parametrised credit-based link fault injector, inserted between a router output port and the neighbour input port in simulation/emulation platforms.
- Parses each packet's header, source PE, edge and timestamp flits.
- On packets that pass the service/app/producer/consumer filter, a pseudo-random draw decides whether to inject a fault.
- Fault modes: HANG, which blocks the link for a programmable number of cycles, or CORRUPT, which XORs a mask into a programmable number of flits.
- Configuration and statistics use ports, not files.

---
 rtl/link_fault_injector.sv | 215 +++++++++++++++++++++
 tb/tb_link_fault_injector.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/link_fault_injector.sv
// -----------------------------------------------------------------------------
// link_fault_injector
//
// Sits on a credit-based link between a router output port and the neighbour
// input port. It parses every packet (header, source PE, edge, timestamp...).
// For packets whose service code and edge fields pass the configured filter,
// a pseudo-random draw decides whether to inject a fault:
//   HANG    : block the link (valid and credit forced low) for hang_len_i cycles
//   CORRUPT : XOR corrupt_mask_i into the next corrupt_len_i flits
// In all other cases the link is a pure combinational pass-through.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   tx_i/eop_tx_i/data_tx_i       upstream flit (valid, end-of-packet, data)
//   cr_tx_o                       credit returned to upstream
//   rx_o/eop_rx_o/data_rx_o       downstream flit (valid, end-of-packet, data)
//   cr_rx_i                       credit from downstream
//   enable_i, mode_i              injection enable, 0=HANG 1=CORRUPT
//   tick_i, tick_begin_i          faults allowed once tick_i >= tick_begin_i
//   chance_i                      probability (0 never, 255 always)
//   filter_app/prod/cons_i        edge field match, 8'hFF is a wildcard
//   hang_len_i, corrupt_len_i     fault lengths (0 = no effect)
//   corrupt_mask_i                XOR mask for CORRUPT
//   fault_o                       one-cycle pulse per injected fault
//   pkt_cnt_o, fault_cnt_o        saturating statistics
// -----------------------------------------------------------------------------
module link_fault_injector #(
  parameter int unsigned FLIT_WIDTH    = 32,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter logic [7:0]  SERVICE_MATCH = 8'h01,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  tx_i,
  output logic                  cr_tx_o,
  input  logic                  eop_tx_i,
  input  logic [FLIT_WIDTH-1:0] data_tx_i,
  output logic                  rx_o,
  input  logic                  cr_rx_i,
  output logic                  eop_rx_o,
  output logic [FLIT_WIDTH-1:0] data_rx_o,
  input  logic                  enable_i,
  input  logic                  mode_i,
  input  logic [31:0]           tick_i,
  input  logic [31:0]           tick_begin_i,
  input  logic [7:0]            chance_i,
  input  logic [7:0]            filter_app_i,
  input  logic [7:0]            filter_prod_i,
  input  logic [7:0]            filter_cons_i,
  input  logic [CNT_WIDTH-1:0]  hang_len_i,
  input  logic [CNT_WIDTH-1:0]  corrupt_len_i,
  input  logic [FLIT_WIDTH-1:0] corrupt_mask_i,
  output logic                  fault_o,
  output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]  fault_cnt_o
);

  typedef enum logic [2:0] {
    ST_HEADER,
    ST_SRCPE,
    ST_EDGE,
    ST_HANG,
    ST_CORRUPT,
    ST_TAIL
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] len_cnt_reg;
  logic [CNT_WIDTH-1:0] pkt_cnt_reg;
  logic [CNT_WIDTH-1:0] fault_cnt_reg;
  logic [15:0]          lfsr_reg;
  logic                 fault_reg;

  logic        hang_active;
  logic        corrupt_active;
  logic        hs;
  logic        service_ok;
  logic        filter_match;
  logic        draw_hit;
  logic        count_pkt;
  logic        fault_now;
  logic [15:0] lfsr_step;

  // ---------------------------------------------------------------------------
  // Datapath: pass-through with HANG / CORRUPT overrides
  // ---------------------------------------------------------------------------
  assign hang_active    = (state_reg == ST_HANG);
  assign corrupt_active = (state_reg == ST_CORRUPT);

  assign rx_o      = tx_i & ~hang_active;
  assign cr_tx_o   = cr_rx_i & ~hang_active;
  assign eop_rx_o  = eop_tx_i;
  assign data_rx_o = corrupt_active ? (data_tx_i ^ corrupt_mask_i) : data_tx_i;

  // A flit only counts as transferred when it is actually visible downstream,
  // so a blocked (HANG) link never advances the packet parser.
  assign hs = tx_i & cr_rx_i & ~hang_active;

  // ---------------------------------------------------------------------------
  // Packet classification
  // ---------------------------------------------------------------------------
  assign service_ok = (tick_i >= tick_begin_i) && (data_tx_i[23:16] == SERVICE_MATCH);

  assign filter_match = ((filter_app_i  == 8'hFF) || (filter_app_i  == data_tx_i[31:24])) &&
                        ((filter_prod_i == 8'hFF) || (filter_prod_i == data_tx_i[23:16])) &&
                        ((filter_cons_i == 8'hFF) || (filter_cons_i == data_tx_i[7:0]));

  // The draw uses the LFSR value before it advances for this packet.
  always_comb begin
    draw_hit = 1'b0;
    if (chance_i == 8'hFF) begin
      draw_hit = 1'b1;
    end else if (chance_i != 8'h00) begin
      draw_hit = (lfsr_reg[7:0] < chance_i);
    end
  end

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
  assign lfsr_step = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

  assign count_pkt = hs && (state_reg == ST_EDGE) && filter_match;
  assign fault_now = count_pkt && enable_i && draw_hit;

  // ---------------------------------------------------------------------------
  // FSM, LFSR and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_HEADER;
      len_cnt_reg   <= CNT_ZERO;
      pkt_cnt_reg   <= CNT_ZERO;
      fault_cnt_reg <= CNT_ZERO;
      lfsr_reg      <= LFSR_SEED;
      fault_reg     <= 1'b0;
    end else begin
      fault_reg <= fault_now;

      if (count_pkt) begin
        lfsr_reg <= lfsr_step;
        if (pkt_cnt_reg != CNT_MAX) begin
          pkt_cnt_reg <= pkt_cnt_reg + CNT_ONE;
        end
      end

      if (fault_now && (fault_cnt_reg != CNT_MAX)) begin
        fault_cnt_reg <= fault_cnt_reg + CNT_ONE;
      end

      case (state_reg)
        ST_HEADER: begin
          if (hs) begin
            state_reg <= service_ok ? ST_SRCPE : ST_TAIL;
          end
        end
        ST_SRCPE: begin
          if (hs) begin
            state_reg <= ST_EDGE;
          end
        end
        ST_EDGE: begin
          if (hs) begin
            // mode_i and the lengths are only looked at here; the fault in
            // progress is then driven purely by len_cnt_reg.
            if (fault_now && !mode_i && (hang_len_i != CNT_ZERO)) begin
              state_reg   <= ST_HANG;
              len_cnt_reg <= hang_len_i;
            end else if (fault_now && mode_i && (corrupt_len_i != CNT_ZERO)) begin
              state_reg   <= ST_CORRUPT;
              len_cnt_reg <= corrupt_len_i;
            end else begin
              state_reg <= ST_TAIL;
            end
          end
        end
        ST_HANG: begin
          // Counts clock cycles, not flits: the link is blocked for exactly
          // the loaded number of cycles.
          len_cnt_reg <= len_cnt_reg - CNT_ONE;
          if (len_cnt_reg == CNT_ONE) begin
            state_reg <= ST_TAIL;
          end
        end
        ST_CORRUPT: begin
          if (hs) begin
            len_cnt_reg <= len_cnt_reg - CNT_ONE;
            if (len_cnt_reg == CNT_ONE) begin
              state_reg <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          state_reg <= ST_TAIL;
        end
        default: begin
          state_reg <= ST_HEADER;
        end
      endcase

      // End of packet wins over every transition above.
      if (hs && eop_tx_i) begin
        state_reg <= ST_HEADER;
      end
    end
  end

  assign fault_o     = fault_reg;
  assign pkt_cnt_o   = pkt_cnt_reg;
  assign fault_cnt_o = fault_cnt_reg;

endmodule

// File: tb/tb_link_fault_injector.sv
// -----------------------------------------------------------------------------
// tb_link_fault_injector
//
// Directed packets are driven one cycle at a time. For every packet a
// packet-level model decides up front (from the header, edge fields, config
// and a model LFSR) whether a fault happens, how many cycles are blocked and
// which flits are XORed, and produces per-cycle expectations. A single compare
// process checks all DUT outputs every cycle; literal checks pin key results.
// -----------------------------------------------------------------------------
module tb_link_fault_injector;

  localparam int          CW   = 4;
  localparam logic [CW-1:0] MAXC = '1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          tx_i = 1'b0;
  logic          cr_tx_o;
  logic          eop_tx_i = 1'b0;
  logic [31:0]   data_tx_i = '0;
  logic          rx_o;
  logic          cr_rx_i = 1'b1;
  logic          eop_rx_o;
  logic [31:0]   data_rx_o;
  logic          enable_i = 1'b0;
  logic          mode_i = 1'b0;
  logic [31:0]   tick_i = 32'd100;
  logic [31:0]   tick_begin_i = 32'd0;
  logic [7:0]    chance_i = 8'hFF;
  logic [7:0]    filter_app_i = 8'hFF;
  logic [7:0]    filter_prod_i = 8'hFF;
  logic [7:0]    filter_cons_i = 8'hFF;
  logic [CW-1:0] hang_len_i = '0;
  logic [CW-1:0] corrupt_len_i = '0;
  logic [31:0]   corrupt_mask_i = '0;
  logic          fault_o;
  logic [CW-1:0] pkt_cnt_o;
  logic [CW-1:0] fault_cnt_o;

  link_fault_injector #(
    .FLIT_WIDTH   (32),
    .CNT_WIDTH    (CW),
    .SERVICE_MATCH(8'h01),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .tx_i          (tx_i),
    .cr_tx_o       (cr_tx_o),
    .eop_tx_i      (eop_tx_i),
    .data_tx_i     (data_tx_i),
    .rx_o          (rx_o),
    .cr_rx_i       (cr_rx_i),
    .eop_rx_o      (eop_rx_o),
    .data_rx_o     (data_rx_o),
    .enable_i      (enable_i),
    .mode_i        (mode_i),
    .tick_i        (tick_i),
    .tick_begin_i  (tick_begin_i),
    .chance_i      (chance_i),
    .filter_app_i  (filter_app_i),
    .filter_prod_i (filter_prod_i),
    .filter_cons_i (filter_cons_i),
    .hang_len_i    (hang_len_i),
    .corrupt_len_i (corrupt_len_i),
    .corrupt_mask_i(corrupt_mask_i),
    .fault_o       (fault_o),
    .pkt_cnt_o     (pkt_cnt_o),
    .fault_cnt_o   (fault_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_err = 0;
  int n_checks = 0;

  // expectations for the current cycle
  logic          chk_en = 1'b0;
  logic          exp_rx, exp_cr, exp_eop, exp_fault;
  logic [31:0]   exp_data;
  logic [CW-1:0] exp_pkt, exp_fcnt;

  // model state
  logic [CW-1:0] m_pkt = '0;
  logic [CW-1:0] m_fcnt = '0;
  logic          m_pulse = 1'b0;
  logic [15:0]   m_lfsr = SEED;
  logic          rst_req = 1'b1;

  // observation
  logic [31:0] dn[$];
  int          blk = 0;
  int          pulses = 0;

  logic [31:0] pf [0:15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAXC) ? v : v + 1'b1;
  endfunction

  function automatic bit fmatch(input logic [7:0] f, input logic [7:0] v);
    return (f == 8'hFF) || (f == v);
  endfunction

  // compare process: every cycle, away from the clock edge
  always @(negedge clk_i) begin
    #2;
    if (chk_en) begin
      chk("rx_o", rx_o, exp_rx);
      chk("cr_tx_o", cr_tx_o, exp_cr);
      chk("eop_rx_o", eop_rx_o, exp_eop);
      chk("data_rx_o", data_rx_o, exp_data);
      chk("fault_o", fault_o, exp_fault);
      chk("pkt_cnt_o", pkt_cnt_o, exp_pkt);
      chk("fault_cnt_o", fault_cnt_o, exp_fcnt);
      if (rx_o && cr_rx_i) dn.push_back(data_rx_o);
      if (tx_i && !rx_o) blk++;
      if (fault_o) pulses++;
    end
  end

  // one clock of stimulus plus its expectations
  task automatic cycle(input logic tx, input logic eop, input logic [31:0] d, input logic cr,
                       input logic e_rx, input logic e_cr, input logic [31:0] e_d);
    @(negedge clk_i);
    exp_fault = m_pulse;
    m_pulse   = 1'b0;
    exp_pkt   = m_pkt;
    exp_fcnt  = m_fcnt;
    rst_ni    = ~rst_req;
    tx_i      = tx;
    eop_tx_i  = eop;
    data_tx_i = d;
    cr_rx_i   = cr;
    exp_rx    = e_rx;
    exp_cr    = e_cr;
    exp_eop   = eop;
    exp_data  = e_d;
    chk_en    = 1'b1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic clr();
    dn.delete();
    blk = 0;
    pulses = 0;
  endtask

  task automatic mk_pkt(input logic [7:0] svc, input logic [7:0] app, input logic [7:0] prod,
                        input logic [7:0] cons, input logic [31:0] ts);
    pf[0] = {8'hA0, svc, 16'h0F0F};
    pf[1] = 32'h0000_0042;
    pf[2] = {app, prod, 8'h00, cons};
    pf[3] = ts;
    for (int i = 4; i < 16; i++) pf[i] = 32'hC0DE_0000 | i;
  endtask

  // Packet-level model: decide the fate of the whole packet, then drive it.
  task automatic send_pkt(input int n, input int stall_at, input bit flip);
    bit          elig, match, draw, fault;
    int          hang, corr;
    logic        last;
    logic [31:0] ed;
    elig  = (tick_i >= tick_begin_i) && (pf[0][23:16] == 8'h01);
    match = elig && (n >= 4) && fmatch(filter_app_i, pf[2][31:24]) &&
            fmatch(filter_prod_i, pf[2][23:16]) && fmatch(filter_cons_i, pf[2][7:0]);
    draw  = (chance_i == 8'hFF) || ((chance_i != 8'h00) && (m_lfsr[7:0] < chance_i));
    fault = match && enable_i && draw;
    hang  = (fault && !mode_i) ? int'(hang_len_i) : 0;
    corr  = (fault && mode_i) ? int'(corrupt_len_i) : 0;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      if (i == 3) repeat (hang) cycle(1'b1, last, pf[i], 1'b1, 1'b0, 1'b0, pf[i]);
      ed = (i >= 3 && i < 3 + corr) ? (pf[i] ^ corrupt_mask_i) : pf[i];
      if (i == stall_at) cycle(1'b1, last, pf[i], 1'b0, 1'b1, 1'b0, ed);
      cycle(1'b1, last, pf[i], 1'b1, 1'b1, 1'b1, ed);
      if (i == 2 && match) begin
        m_lfsr = lfsr_next(m_lfsr);
        m_pkt  = sat_inc(m_pkt);
        if (fault) begin
          m_fcnt  = sat_inc(m_fcnt);
          m_pulse = 1'b1;
        end
      end
      if (i == 2 && flip) begin
        // change the controls only after the edge flit has been accepted
        @(posedge clk_i);
        #1;
        mode_i   = ~mode_i;
        enable_i = ~enable_i;
      end
    end
    idle();
    if (flip) begin
      mode_i   = ~mode_i;
      enable_i = ~enable_i;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset, no traffic ----
    rst_req = 1'b1;
    idle();
    idle();
    rst_req = 1'b0;
    idle();
    #3;
    chk("reset_pkt_cnt", pkt_cnt_o, 0);
    chk("reset_fault_cnt", fault_cnt_o, 0);
    chk("reset_fault_o", fault_o, 0);

    // ---- enable off: untouched, counted ----
    clr();
    enable_i = 1'b0;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_1000);
    send_pkt(6, 4, 1'b0);
    #3;
    chk("t1_pkt_cnt", pkt_cnt_o, 1);
    chk("t1_fault_cnt", fault_cnt_o, 0);
    chk("t1_pulses", pulses, 0);
    chk("t1_ts", dn[3], 32'h0000_1000);

    // ---- HANG for 5 cycles ----
    clr();
    enable_i = 1'b1; mode_i = 1'b0; hang_len_i = 4'd5; chance_i = 8'hFF;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_2000);
    send_pkt(6, -1, 1'b0);
    #3;
    chk("t2_blocked_cycles", blk, 5);
    chk("t2_pulses", pulses, 1);
    chk("t2_fault_cnt", fault_cnt_o, 1);
    chk("t2_ts", dn[3], 32'h0000_2000);
    chk("t2_flits", dn.size(), 6);

    // ---- CORRUPT 2 flits, controls flipped mid-packet ----
    clr();
    mode_i = 1'b1; corrupt_len_i = 4'd2; corrupt_mask_i = 32'hFFFF_0000;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_1234);
    send_pkt(6, 4, 1'b1);
    #3;
    chk("t3_ts", dn[3], 32'hFFFF_1234);
    chk("t3_flit4", dn[4], 32'h3F21_0004);
    chk("t3_flit5", dn[5], 32'hC0DE_0005);
    chk("t3_fault_cnt", fault_cnt_o, 2);

    // ---- producer filter mismatch ----
    clr();
    filter_prod_i = 8'h03;
    mk_pkt(8'h01, 8'h11, 8'h04, 8'h33, 32'h0000_3000);
    send_pkt(6, -1, 1'b0);
    #3;
    chk("t4_pkt_cnt", pkt_cnt_o, 3);
    chk("t4_pulses", pulses, 0);
    chk("t4_ts", dn[3], 32'h0000_3000);
    filter_prod_i = 8'hFF;

    // ---- wrong service, early tick, short packet, then a good one ----
    clr();
    mode_i = 1'b0; hang_len_i = 4'd2;
    mk_pkt(8'h02, 8'h11, 8'h22, 8'h33, 32'h0000_4000);
    send_pkt(6, -1, 1'b0);
    tick_i = 32'd5; tick_begin_i = 32'd10;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_4001);
    send_pkt(6, -1, 1'b0);
    tick_i = 32'd10;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_4002);
    send_pkt(2, -1, 1'b0);
    #3;
    chk("t5_pkt_cnt", pkt_cnt_o, 3);
    chk("t5_blocked", blk, 0);
    clr();
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_4003);
    send_pkt(5, -1, 1'b0);
    #3;
    chk("t5_good_pkt_cnt", pkt_cnt_o, 4);
    chk("t5_good_blocked", blk, 2);

    // ---- corrupt length longer than packet, then clean, then length 0 ----
    mode_i = 1'b1; corrupt_len_i = 4'd10; corrupt_mask_i = 32'h0F0F_F0F0;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_5000);
    send_pkt(6, 3, 1'b0);
    enable_i = 1'b0;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_5001);
    send_pkt(7, -1, 1'b0);
    enable_i = 1'b1; corrupt_len_i = 4'd0;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_5002);
    send_pkt(6, -1, 1'b0);

    // ---- reset in the middle of a HANG ----
    mode_i = 1'b0; hang_len_i = 4'd8;
    mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_6000);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, pf[i], 1'b1, 1'b1, 1'b1, pf[i]);
    m_lfsr  = lfsr_next(m_lfsr);
    m_pkt   = sat_inc(m_pkt);
    m_fcnt  = sat_inc(m_fcnt);
    m_pulse = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, pf[3], 1'b1, 1'b0, 1'b0, pf[3]);
    m_pkt = '0; m_fcnt = '0; m_pulse = 1'b0; m_lfsr = SEED;
    rst_req = 1'b1;
    cycle(1'b1, 1'b0, pf[3], 1'b1, 1'b1, 1'b1, pf[3]);
    #3;
    chk("t7_rst_rx", rx_o, 1);
    chk("t7_rst_pkt_cnt", pkt_cnt_o, 0);
    chk("t7_rst_fault_cnt", fault_cnt_o, 0);
    rst_req = 1'b0;
    idle();
    idle();

    // ---- chance 0 over 100 packets ----
    chance_i = 8'h00;
    for (int k = 0; k < 100; k++) begin
      mk_pkt(8'h01, 8'h11, 8'h22, 8'(k), 32'h0000_7000 + k);
      send_pkt(4, -1, 1'b0);
    end
    #3;
    chk("t8_fault_cnt", fault_cnt_o, 0);
    chk("t8_pkt_cnt_sat", pkt_cnt_o, 15);

    // ---- partial chance, decided by the LFSR ----
    chance_i = 8'h80; mode_i = 1'b1; corrupt_len_i = 4'd1; corrupt_mask_i = 32'h0000_00FF;
    for (int k = 0; k < 10; k++) begin
      mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_8000 + k);
      send_pkt(5, -1, 1'b0);
    end

    // ---- fault counter saturation ----
    chance_i = 8'hFF; corrupt_len_i = 4'd0;
    for (int k = 0; k < 20; k++) begin
      mk_pkt(8'h01, 8'h11, 8'h22, 8'h33, 32'h0000_9000 + k);
      send_pkt(4, -1, 1'b0);
    end
    #3;
    chk("t10_fault_cnt_sat", fault_cnt_o, 15);

    idle();
    #3;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
